// File: rtl/aes.sv
// AES block cipher engine for 128-bit data with an iterative key schedule.
// The key schedule grows one 32-bit word per clock after reset; once it is
// complete the block continuously encrypts `in` and, when the AES_DECRYPT_EN
// macro is defined, decrypts its own ciphertext one cycle later. Without
// AES_DECRYPT_EN no inverse logic exists and decryption_out is constant 0.
module aes #(
    parameter int Nk = 4,
    parameter int Nr = 10
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [127:0]              in,
    input  logic [32*Nk-1:0]          key,
    output logic [32*4*(Nr+1)-1:0]    round_keys,
    output logic [127:0]              encryption_out,
    output logic [127:0]              decryption_out
);

    localparam int NW = 4 * (Nr + 1);
    localparam int CW = $clog2(NW + 1);

    logic [32*NW-1:0] roundKeys_q, roundKeys_d;
    logic [CW-1:0]    wordCnt_q, wordCnt_d;
    logic [7:0]       rcon_q, rcon_d;
    logic [127:0]     encryption_q;
    logic             expDone;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254; zero maps to zero naturally.
    function automatic logic [7:0] ginv(input logic [7:0] x);
        logic [7:0] r;
        logic [7:0] s;
        r = 8'h01;
        s = x;
        for (int i = 1; i < 8; i++) begin
            s = gmul(s, s);
            r = gmul(r, s);
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] v;
        v = ginv(x);
        return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] subWord(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [127:0] subBytes(input logic [127:0] s);
        logic [127:0] o;
        for (int k = 0; k < 16; k++) o[127-8*k -: 8] = sbox(s[127-8*k -: 8]);
        return o;
    endfunction

    function automatic logic [127:0] shiftRows(input logic [127:0] s);
        logic [127:0] o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
        return o;
    endfunction

    // Column mix with a circulant coefficient row; reused for the inverse.
    function automatic logic [127:0] mixWith(input logic [127:0] s, input logic [31:0] coef);
        logic [127:0] o;
        logic [7:0]   acc;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++)
                    acc = acc ^ gmul(s[127-8*(4*c+j) -: 8], coef[31-8*((j-r+4)%4) -: 8]);
                o[127-8*(4*c+r) -: 8] = acc;
            end
        return o;
    endfunction

    function automatic logic [127:0] roundKey(input logic [32*NW-1:0] rks, input int r);
        return rks[(Nr-r)*128 +: 128];
    endfunction

    function automatic logic [127:0] cipher(input logic [127:0] pt, input logic [32*NW-1:0] rks);
        logic [127:0] s;
        s = pt ^ roundKey(rks, 0);
        for (int r = 1; r < Nr; r++)
            s = mixWith(shiftRows(subBytes(s)), 32'h02030101) ^ roundKey(rks, r);
        return shiftRows(subBytes(s)) ^ roundKey(rks, Nr);
    endfunction

`ifdef AES_DECRYPT_EN
    function automatic logic [7:0] invSbox(input logic [7:0] x);
        logic [7:0] v;
        v = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
        return ginv(v);
    endfunction

    function automatic logic [127:0] invSubBytes(input logic [127:0] s);
        logic [127:0] o;
        for (int k = 0; k < 16; k++) o[127-8*k -: 8] = invSbox(s[127-8*k -: 8]);
        return o;
    endfunction

    function automatic logic [127:0] invShiftRows(input logic [127:0] s);
        logic [127:0] o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
        return o;
    endfunction

    function automatic logic [127:0] invCipher(input logic [127:0] ct, input logic [32*NW-1:0] rks);
        logic [127:0] s;
        s = ct ^ roundKey(rks, Nr);
        for (int r = Nr - 1; r >= 1; r--)
            s = mixWith(invSubBytes(invShiftRows(s)) ^ roundKey(rks, r), 32'h0e0b0d09);
        return invSubBytes(invShiftRows(s)) ^ roundKey(rks, 0);
    endfunction
`endif

    assign expDone = (wordCnt_q == CW'(NW));

    // Next key-schedule word: load the raw key first, then one derived word per cycle.
    always_comb begin
        int         idx;
        logic [31:0] temp;
        logic [31:0] prev;
        roundKeys_d = roundKeys_q;
        wordCnt_d   = wordCnt_q;
        rcon_d      = rcon_q;
        idx         = int'(wordCnt_q);
        temp        = 32'h0;
        prev        = 32'h0;
        if (wordCnt_q == '0) begin
            roundKeys_d[32*NW-1 -: 32*Nk] = key;
            wordCnt_d = CW'(Nk);
        end else if (!expDone) begin
            temp = roundKeys_q[(NW-idx)*32 +: 32];
            prev = roundKeys_q[(NW-1-idx+Nk)*32 +: 32];
            if (idx % Nk == 0) begin
                temp   = subWord({temp[23:0], temp[31:24]}) ^ {rcon_q, 24'h0};
                rcon_d = xtime(rcon_q);
            end else if (Nk > 6 && idx % Nk == 4) begin
                temp = subWord(temp);
            end
            roundKeys_d[(NW-1-idx)*32 +: 32] = prev ^ temp;
            wordCnt_d = wordCnt_q + 1'b1;
        end
    end

    // Key-schedule state and the ciphertext register, gated until the schedule is complete.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            roundKeys_q  <= '0;
            wordCnt_q    <= '0;
            rcon_q       <= 8'h01;
            encryption_q <= '0;
        end else begin
            roundKeys_q  <= roundKeys_d;
            wordCnt_q    <= wordCnt_d;
            rcon_q       <= rcon_d;
            encryption_q <= expDone ? cipher(in, roundKeys_q) : '0;
        end
    end

`ifdef AES_DECRYPT_EN
    logic [127:0] decryption_q;

    // Plaintext recovered from the registered ciphertext, one cycle behind it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) decryption_q <= '0;
        else          decryption_q <= expDone ? invCipher(encryption_q, roundKeys_q) : '0;
    end

    assign decryption_out = decryption_q;
`else
    assign decryption_out = '0;
`endif

    assign round_keys     = roundKeys_q;
    assign encryption_out = encryption_q;

endmodule

// File: tb/tb_aes.sv
// Directed scoreboard bench for aes: AES-128/192/256 known-answer vectors,
// key-schedule contents, pre-completion gating and mid-expansion reset.
module tb_aes;

`ifdef AES_DECRYPT_EN
    localparam bit DEC_EN = 1'b1;
`else
    localparam bit DEC_EN = 1'b0;
`endif

    localparam logic [127:0] PT1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] PT2  = 128'h54776f204f6e65204e696e652054776f;
    localparam logic [127:0] K128 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] K2   = 128'h5468617473206d79204b756e67204675;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst4, rst6, rst8;
    logic [127:0]  in4, in6, in8;
    logic [127:0]  key4;
    logic [191:0]  key6;
    logic [255:0]  key8;
    logic [1407:0] rk4;
    logic [1663:0] rk6;
    logic [1919:0] rk8;
    logic [127:0]  enc4, enc6, enc8, dec4, dec6, dec8;

    int checks   = 0;
    int failures = 0;
    logic [127:0] expQ[$];
    string        tagQ[$];

    aes #(.Nk(4), .Nr(10)) u4 (.clk(clk), .reset_n(rst4), .in(in4), .key(key4),
        .round_keys(rk4), .encryption_out(enc4), .decryption_out(dec4));
    aes #(.Nk(6), .Nr(12)) u6 (.clk(clk), .reset_n(rst6), .in(in6), .key(key6),
        .round_keys(rk6), .encryption_out(enc6), .decryption_out(dec6));
    aes #(.Nk(8), .Nr(14)) u8 (.clk(clk), .reset_n(rst8), .in(in8), .key(key8),
        .round_keys(rk8), .encryption_out(enc8), .decryption_out(dec8));

    // Record the value the next comparison must see.
    task automatic pushExpected(input string tag, input logic [127:0] value);
        tagQ.push_back(tag);
        expQ.push_back(value);
    endtask

    // Pop the oldest expectation and compare it with what the DUT shows.
    task automatic checkOutput(input logic [127:0] observed);
        logic [127:0] expected;
        string        tag;
        checks++;
        if (expQ.size() == 0) begin
            failures++;
            $display("[TB] FAIL scoreboard_empty observed=%h", observed);
        end else begin
            expected = expQ.pop_front();
            tag      = tagQ.pop_front();
            assert (observed === expected) else begin
                failures++;
                $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
            end
        end
    endtask

    // Advance one rising edge and settle away from it.
    task automatic stepEdge();
        @(posedge clk);
        #1;
    endtask

    // Drive key and plaintext of the AES-128 instance.
    task automatic applyStimulus(input logic [127:0] k, input logic [127:0] p);
        key4 = k;
        in4  = p;
    endtask

    initial begin
        rst4 = 1'b0; rst6 = 1'b0; rst8 = 1'b0;
        applyStimulus('0, '0);
        key6 = '0; key8 = '0; in6 = '0; in8 = '0;
        repeat (2) stepEdge();

        pushExpected("rst_rk4", '0);   checkOutput(128'(|rk4));
        pushExpected("rst_enc4", '0);  checkOutput(enc4);
        pushExpected("rst_dec4", '0);  checkOutput(dec4);
        pushExpected("rst_rk6", '0);   checkOutput(128'(|rk6));
        pushExpected("rst_rk8", '0);   checkOutput(128'(|rk8));
        pushExpected("rst_enc8", '0);  checkOutput(enc8);

        applyStimulus(K128, PT1);
        key6 = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
        key8 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
        in6  = PT1;
        in8  = PT1;
        @(negedge clk);
        rst4 = 1'b1; rst6 = 1'b1; rst8 = 1'b1;

        for (int e = 1; e <= 55; e++) begin
            stepEdge();
            if (e <= 41) begin
                pushExpected("gate_enc4", '0); checkOutput(enc4);
                pushExpected("gate_dec4", '0); checkOutput(dec4);
            end
            if (e == 1) begin
                pushExpected("rk4_load_key", K128);  checkOutput(rk4[1407:1280]);
                pushExpected("rk4_unwritten", '0);   checkOutput(128'(|rk4[1279:0]));
                key4 = {128{1'b1}};
            end
            if (e == 41) begin
                pushExpected("rk4_w0_3", K128);                       checkOutput(rk4[1407:1280]);
                pushExpected("rk4_w4_5", 128'h0000000000000000d6aa74fdd2af72fa); checkOutput({64'h0, rk4[1279:1216]});
                pushExpected("rk4_w40_43", 128'h13111d7fe3944a17f307a78b4d2b30c5); checkOutput(rk4[127:0]);
            end
            if (e == 42) begin
                pushExpected("enc128_c1", 128'h69c4e0d86a7b0430d8cdb78070b4c55a); checkOutput(enc4);
            end
            if (e == 43) begin
                pushExpected("dec128_c1", DEC_EN ? PT1 : 128'h0); checkOutput(dec4);
            end
            if (e <= 47) begin
                pushExpected("gate_enc6", '0); checkOutput(enc6);
                pushExpected("gate_dec6", '0); checkOutput(dec6);
            end
            if (e == 48) begin
                pushExpected("enc192_c2", 128'hdda97ca4864cdfe06eaf70a0ec0d7191); checkOutput(enc6);
            end
            if (e == 49) begin
                pushExpected("dec192_c2", DEC_EN ? PT1 : 128'h0); checkOutput(dec6);
            end
            if (e <= 53) begin
                pushExpected("gate_enc8", '0); checkOutput(enc8);
            end
            if (e == 54) begin
                pushExpected("enc256_c3", 128'h8ea2b7ca516745bfeafc49904b496089); checkOutput(enc8);
            end
            if (e == 55) begin
                pushExpected("dec256_c3", DEC_EN ? PT1 : 128'h0); checkOutput(dec8);
            end
        end

        @(negedge clk);
        rst4 = 1'b0;
        applyStimulus(K2, PT2);
        @(negedge clk);
        rst4 = 1'b1;
        repeat (20) stepEdge();
        pushExpected("mid_rk4_partial", 128'h1); checkOutput(128'(|rk4));
        rst4 = 1'b0;
        #1;
        pushExpected("mid_rst_rk4", '0);  checkOutput(128'(|rk4));
        pushExpected("mid_rst_enc4", '0); checkOutput(enc4);
        pushExpected("mid_rst_dec4", '0); checkOutput(dec4);
        @(negedge clk);
        rst4 = 1'b1;

        for (int e = 1; e <= 43; e++) begin
            stepEdge();
            if (e == 1) begin
                pushExpected("rk4_reload_key", K2); checkOutput(rk4[1407:1280]);
            end
            if (e == 41) begin
                pushExpected("gate2_enc4", '0); checkOutput(enc4);
            end
            if (e == 42) begin
                pushExpected("enc128_v2", 128'h29c3505f571420f6402299b31a02d73a); checkOutput(enc4);
            end
            if (e == 43) begin
                pushExpected("dec128_v2", DEC_EN ? PT2 : 128'h0); checkOutput(dec4);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
